// File: rtl/lookahead_output_arbiter.sv
// lookahead_output_arbiter: round-robin wormhole switch allocator with downstream credit tracking for one output port
// Ports: clk; rst (async, active-low); req_i/head_i/tail_i per input; credit_in (one slot freed downstream);
//        grant_o (one-hot transfer), valid_o (|grant_o), busy_o (locked to a packet), credits_o, overflow_o (sticky).
module lookahead_output_arbiter #(
    parameter int NumInputs = 5,
    parameter int Credits = 4,
    localparam int CntWidth = $clog2(Credits + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NumInputs-1:0] req_i,
    input  logic [NumInputs-1:0] head_i,
    input  logic [NumInputs-1:0] tail_i,
    input  logic                 credit_in,
    output logic [NumInputs-1:0] grant_o,
    output logic                 valid_o,
    output logic                 busy_o,
    output logic [CntWidth-1:0]  credits_o,
    output logic                 overflow_o
);
    localparam int PtrW = NumInputs > 1 ? $clog2(NumInputs) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;
    logic [0:0] state;
    logic [PtrW-1:0] rr_ptr, owner, win, idx;
    logic [CntWidth-1:0] cnt;
    logic [NumInputs-1:0] cand;
    logic found;
    // While locked only the owner is a candidate, so the search below returns owner.
    always_comb begin
        cand = '0;
        if (state == LOCKED) cand[owner] = req_i[owner];
        else cand = req_i & head_i;
        found = 1'b0;
        win = '0;
        idx = '0;
        for (int k = 0; k < NumInputs; k++) begin
            idx = PtrW'((int'(rr_ptr) + k) % NumInputs);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
        grant_o = '0;
        grant_o[win] = rst && found && cnt != '0;
    end
    assign valid_o = |grant_o;
    assign busy_o = rst && state == LOCKED;
    assign credits_o = cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= CntWidth'(Credits);
            rr_ptr <= '0;
            owner <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (valid_o) begin
                if (tail_i[win]) begin
                    state <= IDLE;
                    rr_ptr <= win == PtrW'(NumInputs - 1) ? '0 : win + PtrW'(1);
                end else if (state == IDLE) begin
                    state <= LOCKED;
                    owner <= win;
                end
            end
            if (valid_o && !credit_in) cnt <= cnt - CntWidth'(1);
            else if (!valid_o && credit_in) begin
                if (cnt == CntWidth'(Credits)) overflow_o <= 1'b1;
                else cnt <= cnt + CntWidth'(1);
            end
        end
    end
endmodule

// File: tb/tb_lookahead_output_arbiter.sv
// tb_lookahead_output_arbiter: scoreboard bench with a queue/array reference model and randomized traffic
module tb_lookahead_output_arbiter;
    localparam int N = 5;
    localparam int C = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] req_i = '0, head_i = '0, tail_i = '0;
    logic credit_in = 1'b0;
    logic [N-1:0] grant_o;
    logic valid_o, busy_o, overflow_o;
    logic [2:0] credits_o;
    lookahead_output_arbiter #(.NumInputs(N), .Credits(C)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .head_i(head_i), .tail_i(tail_i),
        .credit_in(credit_in), .grant_o(grant_o), .valid_o(valid_o), .busy_o(busy_o),
        .credits_o(credits_o), .overflow_o(overflow_o)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [N-1:0] grant;
        logic busy;
        int credits;
        logic ovf;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0, cyc = 0;
    int m_owner, m_rr, m_cred;
    bit m_ovf;
    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, got, want);
        end
    endtask
    task automatic model_reset();
        m_owner = -1;
        m_rr = 0;
        m_cred = C;
        m_ovf = 0;
    endtask
    // Drive one cycle of inputs and push what the model says the outputs must be.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] h, input logic [N-1:0] t, input logic c);
        exp_t e;
        int g;
        @(negedge clk);
        #1;
        req_i = r; head_i = h; tail_i = t; credit_in = c;
        g = -1;
        if (m_cred > 0) begin
            if (m_owner >= 0) begin
                if (r[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_rr + k) % N;
                    if (g < 0 && r[i] && h[i]) g = i;
                end
            end
        end
        e.grant = g >= 0 ? N'(1) << g : '0;
        e.busy = m_owner >= 0;
        e.credits = m_cred;
        e.ovf = m_ovf;
        q.push_back(e);
        if (g >= 0) begin
            if (t[g]) begin
                m_owner = -1;
                m_rr = (g + 1) % N;
            end else if (m_owner < 0) m_owner = g;
        end
        m_cred = m_cred - (g >= 0 ? 1 : 0) + (c ? 1 : 0);
        if (m_cred > C) begin
            m_cred = C;
            m_ovf = 1;
        end
    endtask
    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        req_i = '0; head_i = '0; tail_i = '0; credit_in = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_credits", credits_o, C);
        chk("rst_ovf", overflow_o, 0);
        model_reset();
        #1;
        rst = 1'b1;
    endtask
    initial begin
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("grant", grant_o, e.grant);
                chk("valid", valid_o, |e.grant);
                chk("busy", busy_o, e.busy);
                chk("credits", credits_o, e.credits);
                chk("overflow", overflow_o, e.ovf);
            end
        end
    end
    initial begin
        model_reset();
        #12 rst = 1'b1;
        for (int i = 0; i < 6; i++) step(5'b00001, 5'b00001, 5'b00001, 0);
        do_reset();
        for (int i = 0; i < 12; i++) step(5'b11111, 5'b11111, 5'b11111, 1);
        do_reset();
        step(5'b00010, 5'b00010, 5'b00010, 1);
        step(5'b00101, 5'b00101, 5'b00000, 1);
        step(5'b00101, 5'b00001, 5'b00000, 1);
        step(5'b00101, 5'b00001, 5'b00100, 1);
        step(5'b00001, 5'b00001, 5'b00000, 1);
        do_reset();
        step(5'b01000, 5'b01000, 5'b00000, 0);
        step(5'b00001, 5'b00001, 5'b00001, 0);
        step(5'b00001, 5'b00001, 5'b00001, 0);
        step(5'b01000, 5'b00000, 5'b00000, 0);
        step(5'b01000, 5'b00000, 5'b01000, 0);
        step(5'b00000, 5'b00000, 5'b00000, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step(5'b00010, 5'b00010, 5'b00010, 0);
        step(5'b00010, 5'b00010, 5'b00010, 1);
        step(5'b00010, 5'b00010, 5'b00010, 0);
        step(5'b00000, 5'b00000, 5'b00000, 0);
        do_reset();
        step(5'b00000, 5'b00000, 5'b00000, 1);
        step(5'b00000, 5'b00000, 5'b00000, 0);
        step(5'b00100, 5'b00100, 5'b00000, 0);
        step(5'b00100, 5'b00000, 5'b00000, 0);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step(N'($urandom), N'($urandom), N'($urandom & $urandom), ($urandom_range(0, 99) < 45));
        end
        @(negedge clk);
        @(negedge clk);
        chk("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
